// File: rtl/rr_arbiter8_decoded.sv
// rr_arbiter8_decoded
//   Round-robin arbiter sharing one resource among 2**IDX_W (8) requesters.
//   The grant is presented both as an index and as its one-hot decode. An
//   owner keeps the grant while it holds its request, up to MAX_HOLD cycles,
//   after which the grant is forcibly released with a one-cycle timeout pulse.
//   Every release costs one idle cycle before the next grant.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   en         in   1      arbiter enable; low forces idle, no grant
//   req        in   N      request vector (level), req[i] from requester i
//   gnt        out  N      one-hot grant, all-zero when no owner
//   gnt_idx    out  IDX_W  index of current owner, 0 when gnt_valid=0
//   gnt_valid  out  1      a grant is active (equals |gnt)
//   timeout    out  1      1-cycle pulse: grant revoked by MAX_HOLD limit
module rr_arbiter8_decoded #(
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [(1<<IDX_W)-1:0]   req,
    output logic [(1<<IDX_W)-1:0]   gnt,
    output logic [IDX_W-1:0]        gnt_idx,
    output logic                    gnt_valid,
    output logic                    timeout
);

    localparam int unsigned N = 1 << IDX_W;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last_ptr;
    logic [7:0]       hold_cnt;

    logic             found;
    logic [IDX_W-1:0] winner;
    logic [N-1:0]     winner_dec;

    // Rotating priority search: start just after the last owner, so the most
    // recent owner is considered last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'(32'(last_ptr) + k);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        winner_dec = '0;
        if (found) begin
            winner_dec[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            last_ptr  <= '1;
            hold_cnt  <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && found) begin
                        state     <= GRANT;
                        gnt       <= winner_dec;
                        gnt_idx   <= winner;
                        gnt_valid <= 1'b1;
                        last_ptr  <= winner;
                        hold_cnt  <= 8'd1;
                    end
                end
                GRANT: begin
                    // Priority: disable, then owner release, then hold limit.
                    if (!en || !req[gnt_idx] || hold_cnt == 8'(MAX_HOLD)) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_idx   <= '0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                        timeout   <= en && req[gnt_idx];
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
